// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : counter_pkg
// Description : Shared definitions for the modulo-N counter family.
//               - DIR_UP / DIR_DOWN direction encodings for the 'up' input
//               - mod_max()   : largest count value for a given modulus
//               - params_ok() : parameter legality test used at elaboration
// Revision    : 1.0  initial release
// ============================================================================
package counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Highest value a modulo-'modulus' counter reaches before wrapping.
    function automatic int mod_max(input int modulus);
        return modulus - 1;
    endfunction

    // Legal configurations: WIDTH >= 1 and 2 <= MODULUS <= 2**WIDTH.
    // The 2**WIDTH bound is only evaluated where it fits in a 64-bit value;
    // wider counters always accommodate any int-sized modulus.
    function automatic bit params_ok(input int width, input int modulus);
        longint v_span;
        if (width < 1) begin
            return 1'b0;
        end
        if (modulus < 2) begin
            return 1'b0;
        end
        if (width < 62) begin
            v_span = longint'(1) << width;
            if (longint'(modulus) > v_span) begin
                return 1'b0;
            end
        end
        return 1'b1;
    endfunction

endpackage : counter_pkg
`default_nettype wire

// File: rtl/counter_step.sv
`default_nettype none
// ============================================================================
// Module      : counter_step
// Description : Combinational next-count and terminal-count logic for an
//               up/down modulo counter. Holds no state; the caller owns the
//               register and decides when the step is applied.
// Ports       : i_q    - current count (always within 0..i_max)
//               i_up   - direction, DIR_UP counts up, DIR_DOWN counts down
//               i_max  - largest count value (modulus - 1)
//               o_next - count after one step in direction i_up
//               o_tc   - terminal count: i_q is the last value before a wrap
// Revision    : 1.0  initial release
// ============================================================================
module counter_step
    import counter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_q,
    input  logic             i_up,
    input  logic [WIDTH-1:0] i_max,
    output logic [WIDTH-1:0] o_next,
    output logic             o_tc
);

    logic w_at_max;
    logic w_at_zero;
    logic w_dir_up;

    assign w_at_max  = (i_q == i_max);
    assign w_at_zero = (i_q == '0);
    assign w_dir_up  = (i_up == DIR_UP);

    // Wrap is decided by comparison against i_max rather than by natural
    // binary overflow, so non-power-of-two moduli never leave 0..i_max.
    always_comb begin
        o_next = i_q;
        if (w_dir_up) begin
            o_next = w_at_max ? '0 : (i_q + WIDTH'(1));
        end else begin
            o_next = w_at_zero ? i_max : (i_q - WIDTH'(1));
        end
    end

    assign o_tc = w_dir_up ? w_at_max : w_at_zero;

endmodule : counter_step
`default_nettype wire

// File: rtl/updown_counter_nbit.sv
`default_nettype none
// ============================================================================
// Module      : updown_counter_nbit
// Description : Parametrised synchronous up/down modulo-MODULUS counter with
//               count enable, parallel load (clamped to MAX), preset-to-MAX
//               and a cascade terminal-count output.
//               Per-edge priority: clr > pre > load > en.
// Ports       : clk   - rising-edge clock
//               clr   - synchronous active-high clear, Q <= 0
//               pre   - synchronous preset, Q <= MAX
//               load  - synchronous load, Q <= min(d, MAX)
//               d     - load value
//               en    - count enable, also the cascade carry-in
//               up    - 1 counts up, 0 counts down
//               Q     - registered count
//               Q_bar - ~Q
//               tc    - terminal count (combinational, independent of en)
//               tc_en - tc & en, enable for the next cascaded stage
// Revision    : 1.0  initial release
// ============================================================================
module updown_counter_nbit
    import counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             pre,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Q_bar,
    output logic             tc,
    output logic             tc_en
);

    localparam logic [WIDTH-1:0] C_MAX = WIDTH'(mod_max(MODULUS));

    generate
        if (!params_ok(WIDTH, MODULUS)) begin : g_param_check
            $error("updown_counter_nbit: need WIDTH >= 1 and 2 <= MODULUS <= 2**WIDTH");
        end
    endgenerate

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_load_val;
    logic             w_tc;

    counter_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_q    (r_q),
        .i_up   (up),
        .i_max  (C_MAX),
        .o_next (w_next),
        .o_tc   (w_tc)
    );

    // Out-of-range load values saturate so the count stays within 0..MAX.
    assign w_load_val = (d > C_MAX) ? C_MAX : d;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_q <= '0;
        end else if (pre) begin
            r_q <= C_MAX;
        end else if (load) begin
            r_q <= w_load_val;
        end else if (en) begin
            r_q <= w_next;
        end
    end

    assign Q     = r_q;
    assign Q_bar = ~r_q;
    assign tc    = w_tc;
    // Qualifying tc with en makes a chain of stages advance the next stage
    // exactly once per wrap of this one.
    assign tc_en = w_tc & en;

endmodule : updown_counter_nbit
`default_nettype wire

// File: tb/tb_updown_counter_nbit.sv
`default_nettype none
// ============================================================================
// Module      : tb_updown_counter_nbit
// Description : Self-checking bench for updown_counter_nbit. Drives a
//               MODULUS=16 and a MODULUS=10 instance with shared controls and
//               a two-stage decimal cascade, comparing against an integer
//               modular-arithmetic reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_updown_counter_nbit;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // Shared controls for the single-stage instances
    logic       clr = 1'b0, pre = 1'b0, load = 1'b0, en = 1'b0, up = 1'b0;
    logic [3:0] d = 4'd0;

    logic [3:0] q16, qb16, q10, qb10;
    logic       tc16, tce16, tc10, tce10;

    // Cascade controls and outputs
    logic       c_clr = 1'b0, c_en = 1'b0, c_up = 1'b1;
    logic [3:0] lo_q, lo_qb, hi_q, hi_qb;
    logic       lo_tc, lo_tce, hi_tc, hi_tce;

    updown_counter_nbit #(.WIDTH(4), .MODULUS(16)) dut16 (
        .clk(clk), .clr(clr), .pre(pre), .load(load), .d(d), .en(en), .up(up),
        .Q(q16), .Q_bar(qb16), .tc(tc16), .tc_en(tce16)
    );

    updown_counter_nbit #(.WIDTH(4), .MODULUS(10)) dut10 (
        .clk(clk), .clr(clr), .pre(pre), .load(load), .d(d), .en(en), .up(up),
        .Q(q10), .Q_bar(qb10), .tc(tc10), .tc_en(tce10)
    );

    updown_counter_nbit #(.WIDTH(4), .MODULUS(10)) dut_lo (
        .clk(clk), .clr(c_clr), .pre(1'b0), .load(1'b0), .d(4'd0), .en(c_en), .up(c_up),
        .Q(lo_q), .Q_bar(lo_qb), .tc(lo_tc), .tc_en(lo_tce)
    );

    updown_counter_nbit #(.WIDTH(4), .MODULUS(10)) dut_hi (
        .clk(clk), .clr(c_clr), .pre(1'b0), .load(1'b0), .d(4'd0), .en(lo_tce), .up(c_up),
        .Q(hi_q), .Q_bar(hi_qb), .tc(hi_tc), .tc_en(hi_tce)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state
    int m16 = 0;
    int m10 = 0;
    int mc  = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int model_next(input int q, input int m, input logic c,
                                      input logic p, input logic l, input logic e,
                                      input logic u, input int dv);
        if (c) return 0;
        if (p) return m - 1;
        if (l) return (dv > m - 1) ? m - 1 : dv;
        if (e) return u ? (q + 1) % m : (q + m - 1) % m;
        return q;
    endfunction

    function automatic int model_tc(input int q, input int m, input logic u);
        return u ? int'(q == m - 1) : int'(q == 0);
    endfunction

    // One clock edge on the single-stage instances, then full output check.
    task automatic step(input logic c, input logic p, input logic l,
                        input logic e, input logic u, input int dv);
        clr = c; pre = p; load = l; en = e; up = u; d = 4'(dv);
        @(posedge clk);
        m16 = model_next(m16, 16, c, p, l, e, u, dv);
        m10 = model_next(m10, 10, c, p, l, e, u, dv);
        #1;
        check("q16",   int'(q16),   m16);
        check("qb16",  int'(qb16),  15 - m16);
        check("tc16",  int'(tc16),  model_tc(m16, 16, u));
        check("tce16", int'(tce16), model_tc(m16, 16, u) & int'(e));
        check("q10",   int'(q10),   m10);
        check("qb10",  int'(qb10),  15 - m10);
        check("tc10",  int'(tc10),  model_tc(m10, 10, u));
        check("tce10", int'(tce10), model_tc(m10, 10, u) & int'(e));
    endtask

    // One clock edge on the cascade; the pair must read as one decimal value.
    task automatic cstep(input logic c, input logic e, input logic u);
        c_clr = c; c_en = e; c_up = u;
        @(posedge clk);
        if (c)      mc = 0;
        else if (e) mc = u ? (mc + 1) % 100 : (mc + 99) % 100;
        #1;
        check("casc_val", int'(hi_q) * 10 + int'(lo_q), mc);
        check("casc_lo_tce", int'(lo_tce),
              int'(e) & (u ? int'(mc % 10 == 9) : int'(mc % 10 == 0)));
    endtask

    initial begin
        // Reset, then count up through a full wrap and two more
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 18; i++) step(0, 0, 0, 1, 1, 0);

        // Down-count through zero from 2
        step(0, 0, 1, 0, 0, 2);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, 0);

        // Load clamp and in-range load
        step(0, 0, 1, 1, 1, 12);
        step(0, 0, 1, 1, 1, 5);

        // Priority ladder and hold
        step(1, 1, 1, 1, 1, 3);
        step(0, 1, 1, 1, 1, 3);
        step(0, 0, 1, 1, 1, 3);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, int'($urandom_range(0, 15)));

        // Mid-count clear, resume, preset at Q=4
        step(1, 0, 0, 0, 1, 0);
        for (int i = 0; i < 7; i++) step(0, 0, 0, 1, 1, 0);
        step(1, 0, 0, 1, 1, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 1, 0);
        step(0, 1, 0, 1, 1, 0);

        // Randomized traffic with rare controls
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 19) == 0), ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0),
                 1'($urandom), int'($urandom_range(0, 15)));
        end

        // Cascade: 00..99 and wrap, then down from 00
        cstep(1, 0, 1);
        for (int i = 0; i < 120; i++) cstep(0, 1, 1);
        cstep(1, 0, 0);
        for (int i = 0; i < 3; i++) cstep(0, 1, 0);
        for (int i = 0; i < 60; i++) cstep(0, ($urandom_range(0, 3) != 0), 1'($urandom));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_updown_counter_nbit
`default_nettype wire

// File: doc/updown_counter_nbit.md
Name: updown_counter_nbit

Overview:
- Parametrised synchronous up/down modulo-N counter; next generation of the team's fixed 4-bit up and down counters.
- Adds runtime direction control, count enable, parallel load, preset-to-max, configurable modulus and a cascade terminal-count output.
- Used as the general counting primitive in lab designs: timers, dividers, multi-stage counters.

Parameters:
- WIDTH, 4, counter width in bits; must be at least 1.
- MODULUS, 16, count range 0..MODULUS-1; must satisfy 2 <= MODULUS <= 2^WIDTH; MAX = MODULUS-1.

Ports:
- clk  input  1  rising-edge clock.
- clr  input  1  synchronous active-high reset; clears count.
- pre  input  1  synchronous active-high preset; sets count to MAX.
- load  input  1  synchronous parallel load of d.
- d  input  WIDTH  load value.
- en  input  1  count enable (also the cascade carry-in).
- up  input  1  direction: 1 counts up, 0 counts down.
- Q  output  WIDTH  registered count.
- Q_bar  output  WIDTH  always ~Q.
- tc  output  1  terminal count, combinational.
- tc_en  output  1  tc AND en; cascade enable to the next stage.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (clr). All state changes occur on the rising edge of clk only. No asynchronous paths.
- Priority each edge is clr > pre > load > en. Lower-priority inputs are ignored that cycle.
- clr=1: Q<=0. Reset values are Q=0 and Q_bar=all ones. tc=1 if up=0, else tc=(MAX==0), which is always 0 when MODULUS>=2. tc_en=tc&en.
- pre=1 (clr=0): Q<=MAX. With MODULUS=2^WIDTH this is all ones, matching the legacy preset.
- load=1 (clr=pre=0): Q<=d if d<=MAX, else Q<=MAX (clamped). Counting is never performed in a load cycle.
- en=1, no control active:
  - up=1: Q<=(Q==MAX)?0:Q+1.
  - up=0: Q<=(Q==0)?MAX:Q-1.
- en=0, no control active: Q holds.
- Direction change takes effect on the next counting edge; there is no extra latency.
- Arithmetic is WIDTH bits. The wrap compare uses MAX, never natural overflow, so Q never leaves 0..MAX.
- tc = up ? (Q==MAX) : (Q==0). It is independent of en and reflects current Q and up combinationally.
- tc_en is high exactly in the cycle before a wrap. Chaining stages (tc_en to the next stage's en, shared clk/clr/up) forms a wider synchronous counter with no skipped or double counts.
- clr mid-count: the next edge gives Q=0 regardless of en/load/pre. Counting resumes from 0 on the first edge after clr falls.
- Latency: one edge from any control input to Q. tc/tc_en follow Q with zero cycles.

Decomposition:
- Shared package counter_pkg holds:
  - localparams DIR_UP=1'b1, DIR_DOWN=1'b0.
  - a function mod_max(MODULUS) returning MODULUS-1.
  - an elaboration-time parameter check (MODULUS range, WIDTH>=1) reporting $error on violation.
- One combinational sub-module, counter_step: inputs Q, up, MAX; outputs next count and tc. It is reused by a future loadable timer.
- The top module holds only the register and the priority mux.

Test Plan:
- WIDTH=4, MODULUS=16: clr 1 cycle, then en=1, up=1 for 18 edges -> Q goes 0,1,..,15,0,1. tc=1 only while Q=15. tc_en=1 in that cycle.
- Same instance, up=0 from Q=2, en=1 -> Q goes 1,0,15,14. tc=1 while Q=0. Q_bar=~Q every cycle (Q=14 gives Q_bar=0001).
- WIDTH=4, MODULUS=10: up-count wraps 9->0. Down-count from 0 -> 9. load d=12 -> Q=9 (clamped). load d=5 -> Q=5.
- Priority: clr=pre=load=en=1 -> Q=0. pre=load=en=1, d=3 -> Q=MAX. load=en=1, d=3 -> Q=3 with no increment. en=0 -> Q holds for 5 edges.
- Mid-count reset: count up to Q=7, assert clr for 1 edge with en=1 -> Q=0 next edge, then 1,2 after release. pre pulse at Q=4 -> Q=15.
- Cascade: two WIDTH=4, MODULUS=10 stages (low tc_en to high en), up=1 for 120 edges -> combined value counts 00..99, wraps to 00 at edge 100, no glitches. Repeat down from 00 -> 99,98.
